// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg -- shared types and constants for the instruction fetch controller.
//   XLEN / ILEN   : address and instruction widths
//   fetch_state_e : fetch FSM states
//   buf_entry_t   : one fetched-instruction buffer entry {pc, instr}
package fetch_ctrl_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned ILEN    = 32;
   localparam int unsigned ENTRY_W = XLEN + ILEN;

   typedef enum logic [1:0] {
      StIdle,   // one cycle after reset release
      StReq,    // request presented, awaiting grant
      StWait,   // granted, awaiting response
      StDrain   // discarding one stale response after a redirect
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } buf_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf -- small FIFO of fetched {pc, instr} entries between fetch and decode.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   flush              : drop all entries (takes priority over push/pop)
//   push, push_data    : write one entry
//   pop                : release the head entry
//   head               : head entry (undefined when empty)
//   empty, full, count : occupancy status
// Push and pop in the same cycle on a full buffer is accepted and keeps it full.
module fetch_buf
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  buf_entry_t                   push_data,
   input  logic                         pop,
   output buf_entry_t                   head,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   buf_entry_t      mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PtrW'(1);
   endfunction

   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(DEPTH));
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   assign do_pop  = pop & ~empty;
   // A full buffer can still take a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is only consumed while count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch controller with one outstanding memory request and a
// small fetched-instruction buffer towards decode.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc       : taken branch/jump, refetch from redirect_pc
//   id_ready                          : decode accepts the current if_* entry
//   imem_req, imem_addr               : memory request and word-aligned address
//   imem_gnt                          : request accepted this cycle
//   imem_rvalid, imem_rdata           : memory response
//   if_valid, if_instr, if_pc,
//   if_pc_plus4                       : buffer-head instruction towards decode
//   fetch_misalign                    : sticky misaligned-redirect flag
// Build option: define FETCH_CTRL_MISALIGN_CHECK_EN to flag redirects whose target has
// non-zero low bits; otherwise fetch_misalign is tied low. The low two target bits are
// always dropped from the fetch address.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [ILEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc_plus4,
   output logic            fetch_misalign
);

   localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] redirect_addr;

   buf_entry_t      push_entry, head;
   logic            push, pop, buf_empty, buf_full;
   logic [CntW-1:0] buf_count;
   logic [CntW:0]   occ_next;
   logic            room;

   assign redirect_addr = {redirect_pc[XLEN-1:2], 2'b00};
   assign imem_addr     = fetch_pc_q;

   assign if_valid = ~buf_empty;
   assign pop      = if_valid & id_ready;
   // A response is only kept when it belongs to the current fetch stream.
   assign push     = (state_q == StWait) & imem_rvalid & ~redirect_valid;

   assign push_entry.pc    = fetch_pc_q - XLEN'(4);
   assign push_entry.instr = imem_rdata;

   // Occupancy at the end of this cycle ignores the flush on purpose: a redirect must not
   // raise a request that was not already being presented.
   assign occ_next = {1'b0, buf_count} + (CntW+1)'(push) - (CntW+1)'(pop);
   assign room     = occ_next < (CntW+1)'(BUF_DEPTH);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      imem_req   = 1'b0;

      unique case (state_q)
         StIdle: begin
            state_d = StReq;
         end
         StReq: begin
            // Once raised this stays high: only pops can happen while in StReq.
            imem_req = room;
            if (imem_req && imem_gnt) begin
               state_d = redirect_valid ? StDrain : StWait;
            end
         end
         StWait: begin
            if (redirect_valid) begin
               state_d = imem_rvalid ? StReq : StDrain;
            end else if (imem_rvalid) begin
               // Back-to-back request in the response cycle when the buffer has room;
               // otherwise StReq holds the request back until decode pops.
               imem_req = room;
               state_d  = (imem_req && imem_gnt) ? StWait : StReq;
            end
         end
         StDrain: begin
            if (imem_rvalid) begin
               state_d = StReq;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (redirect_valid) begin
         fetch_pc_d = redirect_addr;
      end else if (imem_req && imem_gnt) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // In StWait the fetch PC has already advanced past the granted address, so the
   // response belongs to fetch_pc_q - 4.
   fetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_fetch_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .empty     (buf_empty),
      .full      (buf_full),
      .count     (buf_count)
   );

   assign if_instr    = if_valid ? head.instr : '0;
   assign if_pc       = if_valid ? head.pc : '0;
   assign if_pc_plus4 = if_valid ? head.pc + XLEN'(4) : '0;

`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         misalign_q <= 1'b1;
      end
   end

   assign fetch_misalign = misalign_q;

   logic unused_buf_full;
   assign unused_buf_full = buf_full;
`else
   assign fetch_misalign = 1'b0;

   logic unused_bits;
   assign unused_bits = (^redirect_pc[1:0]) ^ buf_full;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: linear cycle-by-cycle stimulus with hand-computed
// expectations for streaming, back-pressure, redirects, PC wrap, misalignment and reset.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        fetch_misalign;

   int total = 0;
   int bad   = 0;

`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
   localparam logic [31:0] MisExp = 32'd1;
`else
   localparam logic [31:0] MisExp = 32'd0;
`endif

   always #5 clk = ~clk;

   fetch_ctrl #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4),
      .fetch_misalign (fetch_misalign)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply this cycle's inputs, then let combinational outputs settle.
   task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                        input logic redir, input logic [31:0] rpc, input logic rdy);
      imem_gnt       = g;
      imem_rvalid    = rv;
      imem_rdata     = rd;
      redirect_valid = redir;
      redirect_pc    = rpc;
      id_ready       = rdy;
      #1;
   endtask

   initial begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

      // Reset values
      rst = 1'b1;
      #1;
      chk("rst_req",      {31'b0, imem_req},       32'd0);
      chk("rst_addr",     imem_addr,               32'h0);
      chk("rst_valid",    {31'b0, if_valid},       32'd0);
      chk("rst_pc",       if_pc,                   32'h0);
      chk("rst_pc4",      if_pc_plus4,             32'h0);
      chk("rst_instr",    if_instr,                32'h0);
      chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
      tick();
      rst = 1'b0;

      // Idle cycle after release
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("idle_req", {31'b0, imem_req}, 32'd0);
      tick();

      // Zero-wait streaming
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("s1_req",  {31'b0, imem_req}, 32'd1);
      chk("s1_addr", imem_addr,         32'h0);
      chk("s1_val",  {31'b0, if_valid}, 32'd0);
      tick();
      drive(1'b1, 1'b1, 32'h1000_0000, 1'b0, 32'h0, 1'b1);
      chk("s2_req",  {31'b0, imem_req}, 32'd1);
      chk("s2_addr", imem_addr,         32'h4);
      chk("s2_val",  {31'b0, if_valid}, 32'd0);
      tick();
      drive(1'b1, 1'b1, 32'h1000_0004, 1'b0, 32'h0, 1'b1);
      chk("s3_addr",  imem_addr,         32'h8);
      chk("s3_val",   {31'b0, if_valid}, 32'd1);
      chk("s3_pc",    if_pc,             32'h0);
      chk("s3_instr", if_instr,          32'h1000_0000);
      chk("s3_pc4",   if_pc_plus4,       32'h4);
      tick();

      // Back-pressure: decode stalls, buffer fills to two entries
      drive(1'b0, 1'b1, 32'h1000_0008, 1'b0, 32'h0, 1'b0);
      chk("st0_pc",  if_pc,             32'h4);
      chk("st0_req", {31'b0, imem_req}, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
         chk("stall_req",   {31'b0, imem_req}, 32'd0);
         chk("stall_pc",    if_pc,             32'h4);
         chk("stall_instr", if_instr,          32'h1000_0004);
         tick();
      end
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("resume_req",  {31'b0, imem_req}, 32'd1);
      chk("resume_addr", imem_addr,         32'hC);
      chk("resume_pc",   if_pc,             32'h4);
      tick();

      // Redirect in WAIT without response; stale response dropped
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
      chk("buf2_pc",    if_pc,             32'h8);
      chk("buf2_instr", if_instr,          32'h1000_0008);
      chk("rw_req",     {31'b0, imem_req}, 32'd0);
      tick();
      drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
      chk("dr1_val", {31'b0, if_valid}, 32'd0);
      chk("dr1_req", {31'b0, imem_req}, 32'd0);
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("dr1_after_val", {31'b0, if_valid}, 32'd0);
      chk("rd1_addr",      imem_addr,         32'h100);
      chk("rd1_req",       {31'b0, imem_req}, 32'd1);
      tick();
      drive(1'b0, 1'b1, 32'h2000_0100, 1'b0, 32'h0, 1'b1);
      chk("hold_req",  {31'b0, imem_req}, 32'd1);
      chk("hold_addr", imem_addr,         32'h104);
      tick();

      // Redirect together with grant: DRAIN path
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
      chk("r100_pc",    if_pc,             32'h100);
      chk("r100_instr", if_instr,          32'h2000_0100);
      chk("hold2_addr", imem_addr,         32'h104);
      chk("hold2_req",  {31'b0, imem_req}, 32'd1);
      tick();
      drive(1'b0, 1'b1, 32'hBAD0_0104, 1'b0, 32'h0, 1'b1);
      chk("dr2_val", {31'b0, if_valid}, 32'd0);
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("dr2_after_val", {31'b0, if_valid}, 32'd0);
      chk("rd2_addr",      imem_addr,         32'h200);
      chk("rd2_req",       {31'b0, imem_req}, 32'd1);
      tick();

      // Redirect together with response: straight back to REQ
      drive(1'b0, 1'b1, 32'hBAD0_0200, 1'b1, 32'h300, 1'b1);
      chk("rr_req", {31'b0, imem_req}, 32'd0);
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("rr_val",  {31'b0, if_valid}, 32'd0);
      chk("rr_req2", {31'b0, imem_req}, 32'd1);
      chk("rr_addr", imem_addr,         32'h300);
      tick();
      drive(1'b0, 1'b1, 32'h3000_0300, 1'b0, 32'h0, 1'b1);
      chk("r300_addr", imem_addr, 32'h304);
      tick();

      // Wrap at the top of the address space
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      chk("r300_pc",    if_pc,    32'h300);
      chk("r300_instr", if_instr, 32'h3000_0300);
      tick();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("wrap_val",  {31'b0, if_valid}, 32'd0);
      chk("wrap_addr", imem_addr,         32'hFFFF_FFFC);
      tick();
      drive(1'b1, 1'b1, 32'h4000_FFFC, 1'b0, 32'h0, 1'b1);
      chk("wrap_addr0", imem_addr,         32'h0);
      chk("wrap_req0",  {31'b0, imem_req}, 32'd1);
      tick();
      drive(1'b0, 1'b1, 32'h4000_0000, 1'b0, 32'h0, 1'b1);
      chk("wtop_pc",    if_pc,       32'hFFFF_FFFC);
      chk("wtop_pc4",   if_pc_plus4, 32'h0);
      chk("wtop_instr", if_instr,    32'h4000_FFFC);
      tick();

      // Misaligned redirect
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b1);
      chk("w0_pc",    if_pc,                   32'h0);
      chk("w0_pc4",   if_pc_plus4,             32'h4);
      chk("mis_pre",  {31'b0, fetch_misalign}, 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("mis_addr", imem_addr,               32'h100);
      chk("mis_flag", {31'b0, fetch_misalign}, MisExp);
      chk("mis_val",  {31'b0, if_valid},       32'd0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("mis_sticky", {31'b0, fetch_misalign}, MisExp);

      // Asynchronous reset mid-transaction, response during reset ignored
      #2;
      rst = 1'b1;
      #1;
      chk("ar_req",      {31'b0, imem_req},       32'd0);
      chk("ar_addr",     imem_addr,               32'h0);
      chk("ar_misalign", {31'b0, fetch_misalign}, 32'd0);
      drive(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0, 32'h0, 1'b1);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("ar_val",     {31'b0, if_valid}, 32'd0);
      chk("ar_idlereq", {31'b0, imem_req}, 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("ar_req2",  {31'b0, imem_req}, 32'd1);
      chk("ar_addr2", imem_addr,         32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
